fm_master: RTL and testbench

- Bus-master sequencer that drives the factorial slave from the host side: writes the 6-bit operand, starts the operation, polls done, reads the 64-bit result, then clears the slave.
- Sits between the host command interface and the shared bus, on the opposite end of the slave's register interface.
- One transaction in flight at a time.

---
 rtl/fm_master.sv | 203 ++++++++++++++++++++
 tb/tb_fm_master.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fm_master.sv
// rtl/fm_master.sv - bus-master sequencer for the factorial slave (write N, start, poll, read result, clear).
// Optional poll timeout is enabled by defining FM_POLL_TIMEOUT_EN.
module fm_master #(
  parameter logic [7:0]  ADDR_BASE  = 8'h00,
  parameter logic [15:0] POLL_LIMIT = 16'd1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [5:0]  cmd_n,
  output logic        cmd_ready,
  output logic        res_valid,
  output logic [63:0] result,
  output logic        res_err,
  output logic        m_req,
  input  logic        m_grant,
  output logic        m_wr,
  output logic        m_en,
  output logic [7:0]  m_addr,
  output logic [31:0] m_dout,
  input  logic [31:0] m_din
);

  localparam logic [7:0] OFF_START   = 8'h0;
  localparam logic [7:0] OFF_CLEAR   = 8'h1;
  localparam logic [7:0] OFF_DONE    = 8'h2;
  localparam logic [7:0] OFF_OPERAND = 8'h4;
  localparam logic [7:0] OFF_RES_H   = 8'h5;
  localparam logic [7:0] OFF_RES_L   = 8'h6;

  typedef enum logic [3:0] {
    IDLE, REQ, WR_OPERAND, WR_START, POLL_A, POLL_D,
    RDH_A, RDH_D, RDL_A, RDL_D, CLEAR, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  n_q, n_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [63:0] result_q, result_d;
  logic        err_q, err_d;
  logic [31:0] wdata;
`ifdef FM_POLL_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      n_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
`ifdef FM_POLL_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      err_q    <= err_d;
`ifdef FM_POLL_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  // Bus states hold address/direction while waiting for grant; m_en only fires on a granted cycle.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    result_d  = result_q;
    err_d     = err_q;
`ifdef FM_POLL_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    m_req     = 1'b0;
    m_en      = 1'b0;
    m_wr      = 1'b0;
    m_addr    = '0;
    wdata     = '0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          n_d     = cmd_n;
          err_d   = 1'b0;
          state_d = REQ;
        end
      end
      REQ: begin
        m_req   = 1'b1;
        state_d = WR_OPERAND;
      end
      WR_OPERAND: begin
        m_req  = 1'b1;
        m_wr   = 1'b1;
        m_addr = ADDR_BASE + OFF_OPERAND;
        wdata  = {26'b0, n_q};
        if (m_grant) begin
          m_en    = 1'b1;
          state_d = WR_START;
`ifdef FM_POLL_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      WR_START: begin
        m_req  = 1'b1;
        m_wr   = 1'b1;
        m_addr = ADDR_BASE + OFF_START;
        wdata  = 32'h1;
        if (m_grant) begin
          m_en    = 1'b1;
          state_d = POLL_A;
        end
      end
      POLL_A: begin
        m_req  = 1'b1;
        m_addr = ADDR_BASE + OFF_DONE;
        if (m_grant) begin
          m_en    = 1'b1;
          state_d = POLL_D;
`ifdef FM_POLL_TIMEOUT_EN
          cnt_d   = cnt_q + 16'd1;
`endif
        end
      end
      POLL_D: begin
        m_req = 1'b1;
        if (m_din[0]) begin
          state_d = RDH_A;
`ifdef FM_POLL_TIMEOUT_EN
        end else if (cnt_q >= POLL_LIMIT) begin
          err_d   = 1'b1;
          state_d = CLEAR;
`endif
        end else begin
          state_d = POLL_A;
        end
      end
      RDH_A: begin
        m_req  = 1'b1;
        m_addr = ADDR_BASE + OFF_RES_H;
        if (m_grant) begin
          m_en    = 1'b1;
          state_d = RDH_D;
        end
      end
      RDH_D: begin
        m_req   = 1'b1;
        hi_d    = m_din;
        state_d = RDL_A;
      end
      RDL_A: begin
        m_req  = 1'b1;
        m_addr = ADDR_BASE + OFF_RES_L;
        if (m_grant) begin
          m_en    = 1'b1;
          state_d = RDL_D;
        end
      end
      RDL_D: begin
        m_req   = 1'b1;
        lo_d    = m_din;
        state_d = CLEAR;
      end
      CLEAR: begin
        m_req  = 1'b1;
        m_wr   = 1'b1;
        m_addr = ADDR_BASE + OFF_CLEAR;
        wdata  = 32'h1;
        if (m_grant) begin
          m_en     = 1'b1;
          // Staged words reach result only here, so result holds until the next res_valid.
          result_d = err_q ? 64'h0 : {hi_q, lo_q};
          state_d  = DONE;
        end
      end
      DONE: begin
        res_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    m_dout = (m_en && m_wr) ? wdata : 32'h0;
  end

  assign result = result_q;

`ifdef FM_POLL_TIMEOUT_EN
  assign res_err = (state_q == DONE) && err_q;
`else
  assign res_err = 1'b0 && (POLL_LIMIT == 16'd0);
`endif

endmodule

// File: tb/tb_fm_master.sv
// tb/tb_fm_master.sv - randomized self-checking bench for fm_master against a transaction-schedule model.
module tb_fm_master;

  localparam logic [7:0] BASE = 8'h40;
`ifdef FM_POLL_TIMEOUT_EN
  localparam logic [15:0] LIMIT = 16'd4;
`else
  localparam logic [15:0] LIMIT = 16'd1024;
`endif

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic [5:0]  cmd_n;
  logic        cmd_ready;
  logic        res_valid;
  logic [63:0] result;
  logic        res_err;
  logic        m_req;
  logic        m_grant;
  logic        m_wr;
  logic        m_en;
  logic [7:0]  m_addr;
  logic [31:0] m_dout;
  logic [31:0] m_din;

  fm_master #(.ADDR_BASE(BASE), .POLL_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_n(cmd_n),
    .cmd_ready(cmd_ready), .res_valid(res_valid), .result(result),
    .res_err(res_err), .m_req(m_req), .m_grant(m_grant), .m_wr(m_wr),
    .m_en(m_en), .m_addr(m_addr), .m_dout(m_dout), .m_din(m_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
    int          t;
  } txn_t;

  txn_t        exp_q[$];
  bit          gnt[0:255];
  int          tt;
  int          exp_done;
  logic [63:0] exp_res;
  bit          exp_err;
  bit          active;
  bit          done_seen;
  int          need;
  int          pass_cnt = 0;
  int          chk_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0d)", nm, act, exp, tt);
  endtask

  function automatic logic [63:0] fact(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 2; i <= n; i++) r = r * 64'(i);
    return r;
  endfunction

  // Slave: registered read data; done bit rises on the need-th OPDONE read after start.
  logic [5:0]  s_op;
  int          s_polls;
  logic [63:0] s_fact;
  assign s_fact = fact(int'(s_op));

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      s_op    <= '0;
      s_polls <= 0;
      m_din   <= '0;
    end else begin
      m_din <= $urandom;
      if (m_en) begin
        if (m_wr) begin
          if (m_addr == BASE + 8'h4) s_op <= m_dout[5:0];
          else if (m_addr == BASE) s_polls <= 0;
        end else begin
          case (m_addr - BASE)
            8'h2: begin
              s_polls <= s_polls + 1;
              m_din   <= {31'($urandom), (need != 0) && (s_polls + 1 >= need)};
            end
            8'h5: m_din <= s_fact[63:32];
            8'h6: m_din <= s_fact[31:0];
            default: m_din <= $urandom;
          endcase
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (!(m_en && m_wr)) chk("dout_zero", m_dout, 32'h0);
      if (active) chk("cmd_ready", cmd_ready, (tt == 0) || (tt > exp_done));
      if (m_en) begin
        if (exp_q.size() == 0) chk("unexpected_txn", 1, 0);
        else begin
          txn_t e;
          e = exp_q.pop_front();
          chk("txn_wr", m_wr, e.wr);
          chk("txn_addr", m_addr, e.addr);
          chk("txn_data", m_dout, e.data);
          chk("txn_time", tt, e.t);
        end
      end
      if (res_valid) begin
        if (!active) chk("spurious_res_valid", 1, 0);
        else begin
          chk("result", result, exp_res);
          chk("res_err", res_err, exp_err);
          chk("res_time", tt, exp_done);
          done_seen = 1'b1;
        end
      end
    end
  end

  // Each transaction issues on the first granted cycle at or after t; reads add a data cycle.
  task automatic add_txn(inout int t, input bit wr, input logic [7:0] a, input logic [31:0] d);
    txn_t e;
    while (!gnt[t]) t++;
    e.wr = wr; e.addr = a; e.data = d; e.t = t;
    exp_q.push_back(e);
    t += wr ? 1 : 2;
  endtask

  task automatic build(input int n, input int nd, input int mode);
    int t;
    int polls;
    bit tmo;
    for (int i = 0; i < 256; i++) begin
      gnt[i] = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (i >= 200) gnt[i] = 1'b1;
      if (mode == 2 && i >= 3 && i <= 6) gnt[i] = 1'b0;
    end
    tmo   = (nd == 0);
    polls = tmo ? int'(LIMIT) : nd;
    exp_q.delete();
    t = 2;
    add_txn(t, 1'b1, BASE + 8'h4, 32'(n));
    add_txn(t, 1'b1, BASE + 8'h0, 32'h1);
    for (int p = 0; p < polls; p++) add_txn(t, 1'b0, BASE + 8'h2, 32'h0);
    if (!tmo) begin
      add_txn(t, 1'b0, BASE + 8'h5, 32'h0);
      add_txn(t, 1'b0, BASE + 8'h6, 32'h0);
    end
    add_txn(t, 1'b1, BASE + 8'h1, 32'h1);
    exp_done = t;
    exp_res  = tmo ? 64'h0 : fact(n);
    exp_err  = tmo;
    need     = nd;
  endtask

  task automatic run_txn(input int n, input int nd, input int mode, input bit extra, input int rst_at);
    build(n, nd, mode);
    cmd_valid = 1'b1;
    cmd_n     = 6'(n);
    m_grant   = gnt[0];
    tt        = 0;
    done_seen = 1'b0;
    active    = 1'b1;
    for (int t = 1; t <= exp_done + 3; t++) begin
      @(posedge clk);
      #1;
      tt        = t;
      m_grant   = gnt[t];
      cmd_valid = extra && (t <= 5) && ($urandom_range(0, 1) == 1);
      cmd_n     = 6'($urandom);
      if (t == rst_at) begin
        #2;
        active = 1'b0;
        exp_q.delete();
        reset  = 1'b1;
        #1;
        chk("rst_m_req", m_req, 1'b0);
        chk("rst_m_en", m_en, 1'b0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        cmd_valid = 1'b0;
        #1;
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_result", result, 64'h0);
        chk("rst_res_valid", res_valid, 1'b0);
        return;
      end
    end
    chk("res_seen", done_seen, 1'b1);
    chk("txn_left", exp_q.size(), 0);
    active  = 1'b0;
    m_grant = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_n     = '0;
    m_grant   = 1'b0;
    active    = 1'b0;
    need      = 1;
    tt        = 0;
    exp_done  = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_m_req", m_req, 1'b0);
    chk("reset_m_en", m_en, 1'b0);
    chk("reset_m_wr", m_wr, 1'b0);
    chk("reset_res_valid", res_valid, 1'b0);
    chk("reset_res_err", res_err, 1'b0);
    chk("reset_m_addr", m_addr, 8'h0);
    chk("reset_m_dout", m_dout, 32'h0);
    chk("reset_result", result, 64'h0);
    reset = 1'b0;
    #1;
    chk("ready_after_reset", cmd_ready, 1'b1);

    chk("model_fact5", fact(5), 64'h78);
    chk("model_fact20", fact(20), 64'h21C3677C82B40000);
    chk("model_fact0", fact(0), 64'h1);

    run_txn(5, 3, 0, 1'b0, -1);
    run_txn(20, 1, 0, 1'b0, -1);
    chk("model_lat20", exp_done, 11);
    run_txn(3, 1, 2, 1'b0, -1);
    chk("model_lat_stall", exp_done, 15);
    run_txn(9, 2, 0, 1'b1, -1);
    run_txn(0, 1, 0, 1'b0, -1);
    run_txn(1, 1, 1, 1'b0, -1);
    run_txn(7, 3, 0, 1'b0, 4);
    run_txn(6, 1, 0, 1'b0, -1);
    for (int k = 0; k < 12; k++)
      run_txn($urandom_range(0, 63), $urandom_range(1, 4), 1, 1'($urandom_range(0, 1)), -1);
`ifdef FM_POLL_TIMEOUT_EN
    run_txn(6, 0, 0, 1'b0, -1);
    chk("model_lat_timeout", exp_done, 13);
    run_txn(12, 0, 1, 1'b0, -1);
    run_txn(4, 4, 0, 1'b0, -1);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
